i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter: CLK_DIV, default 4, number of clk cycles per bclk half-period; legal values are 1 or more.
REQ-002 Parameter: DATA_W, fixed at 16, the sample width per channel.
REQ-003 Port: clk  input  1  system clock; the only clock in the block.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
REQ-005 Port: sample_l  input  16  left-channel sample, signed two's complement (equalizer dout).
REQ-006 Port: sample_r  input  16  right-channel sample, signed two's complement.
REQ-007 Port: sample_valid  input  1  sample_l/sample_r present a new stereo pair.
REQ-008 Port: sample_ready  output  1  the holding buffer is empty and can accept a pair.
REQ-009 Port: o_bclk  output  1  serial bit clock to the DAC/codec.
REQ-010 Port: o_lrclk  output  1  word select; 0 = left, 1 = right.
REQ-011 Port: o_sdata  output  1  serial data, MSB first, I2S format.
REQ-012 Port: frame_start  output  1  one-clk pulse when a new pair is loaded into the shifter.
REQ-013 Port: underrun  output  1  one-clk pulse when a load finds the holding buffer empty.

Function
REQ-014 A stereo pair SHALL be accepted on a clk edge where sample_valid=1 and sample_ready=1, and SHALL be stored in a 32-bit holding buffer as {sample_l, sample_r}.
REQ-015 sample_ready SHALL equal NOT buf_full, where buf_full is a register; it SHALL go low the cycle after acceptance.
REQ-016 Divider: div_cnt SHALL count 0..CLK_DIV-1 and wrap. o_bclk SHALL toggle on each wrap, so the bclk period is 2*CLK_DIV clk cycles.
REQ-017 Slot counter: bit_cnt (5 bits) SHALL increment modulo 32 on each bclk falling toggle. Each falling toggle begins a new slot numbered bit_cnt.
REQ-018 o_lrclk SHALL be 0 during slots 0-15 and 1 during slots 16-31, changing only on bclk falling toggles.
REQ-019 Shifter: on the falling toggle entering slot 1 (the load event), shreg SHALL be loaded from the holding buffer and buf_full SHALL clear.
REQ-020 On every other falling toggle, shreg SHALL shift left by one with 0 inserted; o_sdata SHALL equal shreg[31].
REQ-021 Resulting slot map: slots 1-16 carry L[15:0]; slots 17-31 and the next frame's slot 0 carry R[15:0]. This gives one-bclk MSB delay after each lrclk edge.
REQ-022 o_sdata and o_lrclk SHALL change only on bclk falling toggles and SHALL be stable across bclk rising toggles.
REQ-023 frame_start SHALL pulse for exactly one clk on every load event.
REQ-024 If buf_full=0 at a load event, shreg SHALL load all zeros (silence) and underrun SHALL pulse together with frame_start.
REQ-025 Simultaneous acceptance and load event on an empty buffer: the load SHALL see the buffer empty (underrun), and the accepted pair SHALL be kept for the next frame.
REQ-026 Simultaneous load event with a full buffer: the load SHALL take the buffer, and sample_ready SHALL rise the following cycle.
REQ-027 Data SHALL pass through bit-exact; there is no scaling, saturation or sign manipulation.

Reset
REQ-028 While reset=0, the following SHALL be cleared asynchronously: o_bclk, o_lrclk, o_sdata, frame_start, underrun, div_cnt, bit_cnt, shreg and buf_full.
REQ-029 While reset=0, sample_ready SHALL be 1.
REQ-030 After reset release, the first bclk rising toggle SHALL occur on the CLK_DIV-th clk edge, and the first load event on the 2*CLK_DIV-th clk edge.
REQ-031 Reset asserted mid-frame SHALL discard the buffer and shifter contents; no partial word SHALL complete.

Verification (CLK_DIV=2, so the bclk period is 4 clk and a frame is 128 clk)
REQ-032 Reset: hold reset=0 for 3 clk -> all outputs 0 and sample_ready=1; then release -> o_bclk rises on the 2nd clk edge.
REQ-033 Single pair: push L=16'hA5F0, R=16'h0F0F before the first load -> sample the rising-edge bits of slots 1..32 and obtain 16'hA5F0 then 16'h0F0F; o_lrclk=0 for slots 0-15; frame_start=1 and underrun=0 at the load.
REQ-034 Underrun: no sample pushed -> frame_start=1 and underrun=1 at the load; o_sdata=0 for the whole frame.
REQ-035 Back-pressure: push pairs P1 and P2 back-to-back -> P1 accepted; sample_ready=0 until the load after P1 is buffered; P2 accepted the cycle after sample_ready rises; P1 and P2 transmitted in consecutive frames.
REQ-036 Collision: assert sample_valid (pair 16'h1234/16'h8001) in the same cycle as a load event with an empty buffer -> underrun=1 this frame; 16'h1234 then 16'h8001 transmitted next frame with underrun=0.
REQ-037 Mid-frame reset: reset=0 during slot 20 -> o_sdata, o_lrclk and o_bclk go 0 without waiting for a clk edge; after release, the next frame underruns unless a new pair is pushed.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S transmitter: a one-pair holding buffer feeding a 32-slot frame shifter.
// bclk and lrclk are derived from clk; serial data changes only on bclk falling toggles.
module i2s_tx #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_l,
    input  logic [DATA_W-1:0] sample_r,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              o_bclk,
    output logic              o_lrclk,
    output logic              o_sdata,
    output logic              frame_start,
    output logic              underrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WORD_W = 2 * DATA_W;

    logic [DIV_W-1:0]  div_cnt;
    logic [4:0]        bit_cnt;
    logic [4:0]        bit_cnt_nxt;
    logic [WORD_W-1:0] hold_buf;
    logic [WORD_W-1:0] shreg;
    logic              buf_full;
    logic              div_wrap;
    logic              fall_tgl;
    logic              load_evt;
    logic              accept;

    assign div_wrap     = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall_tgl     = div_wrap && o_bclk;
    assign bit_cnt_nxt  = bit_cnt + 5'd1;
    assign load_evt     = fall_tgl && (bit_cnt_nxt == 5'd1);
    assign accept       = sample_valid && !buf_full;
    assign sample_ready = !buf_full;
    assign o_sdata      = shreg[WORD_W-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            o_bclk  <= 1'b0;
            bit_cnt <= '0;
            o_lrclk <= 1'b0;
        end else begin
            if (div_wrap) begin
                div_cnt <= '0;
                o_bclk  <= ~o_bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall_tgl) begin
                bit_cnt <= bit_cnt_nxt;
                o_lrclk <= bit_cnt_nxt[4];
            end
        end
    end

    // The load samples buf_full before this edge's acceptance, so a pair
    // arriving on the load edge itself is held for the following frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_buf <= '0;
            buf_full <= 1'b0;
            shreg    <= '0;
        end else begin
            if (accept) begin
                hold_buf <= {sample_l, sample_r};
            end
            if (accept) begin
                buf_full <= 1'b1;
            end else if (load_evt) begin
                buf_full <= 1'b0;
            end
            if (load_evt) begin
                shreg <= buf_full ? hold_buf : '0;
            end else if (fall_tgl) begin
                shreg <= {shreg[WORD_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= load_evt;
            underrun    <= load_evt && !buf_full;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a time-based frame model checked every cycle,
// plus directed frames whose serial words are pinned to literal values.
module tb_i2s_tx;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        o_bclk;
    logic        o_lrclk;
    logic        o_sdata;
    logic        frame_start;
    logic        underrun;

    int vec_count = 0;
    int err_count = 0;

    // Model state: edges since reset release, the buffered pair and the frame word on the wire.
    int          mt;
    bit          m_full;
    bit          m_ld;
    bit          m_acc;
    logic [31:0] m_buf;
    logic [31:0] m_cur;
    bit          e_fs;
    bit          e_ur;

    always #5 clk = ~clk;

    i2s_tx #(.CLK_DIV(D), .DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_l    (sample_l),
        .sample_r    (sample_r),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .o_bclk      (o_bclk),
        .o_lrclk     (o_lrclk),
        .o_sdata     (o_sdata),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    function automatic bit is_load(input int t);
        return (t % (2 * D) == 0) && ((t / (2 * D)) % 32 == 1);
    endfunction

    function automatic int slot_of(input int t);
        return (t / (2 * D)) % 32;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        vec_count++;
        err_count++;
        $display("[TB] FAIL %s: got timeout expected event at %0t", name, $time);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mt = 0; m_full = 0; m_buf = '0; m_cur = '0; e_fs = 0; e_ur = 0;
        end else begin
            mt++;
            m_ld  = is_load(mt);
            m_acc = sample_valid && !m_full;
            e_fs  = m_ld;
            e_ur  = m_ld && !m_full;
            if (m_ld) m_cur = m_full ? m_buf : 32'd0;
            if (m_acc) m_buf = {sample_l, sample_r};
            if (m_acc) m_full = 1;
            else if (m_ld) m_full = 0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            checkOutput("bclk", 32'(o_bclk), 32'((mt / D) % 2));
            checkOutput("lrclk", 32'(o_lrclk), 32'(slot_of(mt) >= 16));
            checkOutput("sdata", 32'(o_sdata), 32'(m_cur[(32 - slot_of(mt)) % 32]));
            checkOutput("sample_ready", 32'(sample_ready), 32'(!m_full));
            checkOutput("frame_start", 32'(frame_start), 32'(e_fs));
            checkOutput("underrun", 32'(underrun), 32'(e_ur));
        end
    end

    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r);
        bit ok;
        ok = 0;
        @(negedge clk);
        sample_l = l;
        sample_r = r;
        sample_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (sample_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout_fail("push accept");
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_load(output logic ur);
        bit ok;
        ok = 0;
        ur = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (frame_start) begin
                ur = underrun;
                ok = 1;
                break;
            end
        end
        if (!ok) timeout_fail("wait frame_start");
    endtask

    // Collects o_sdata at the next 32 bclk rising edges, i.e. slots 1..31 and the following slot 0.
    task automatic capture_word(output logic [31:0] w);
        int   n;
        logic prev;
        w = '0;
        n = 0;
        prev = o_bclk;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (!prev && o_bclk) begin
                w = {w[30:0], o_sdata};
                n++;
            end
            prev = o_bclk;
            if (n == 32) break;
        end
        if (n < 32) timeout_fail("capture word");
    endtask

    initial begin
        logic [31:0] w;
        logic        ur;
        bit          ok;

        reset = 1'b0;
        sample_valid = 1'b0;
        sample_l = '0;
        sample_r = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset bclk", 32'(o_bclk), 32'd0);
        checkOutput("reset lrclk", 32'(o_lrclk), 32'd0);
        checkOutput("reset sdata", 32'(o_sdata), 32'd0);
        checkOutput("reset frame_start", 32'(frame_start), 32'd0);
        checkOutput("reset underrun", 32'(underrun), 32'd0);
        checkOutput("reset ready", 32'(sample_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bclk after 1st edge", 32'(o_bclk), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("bclk after 2nd edge", 32'(o_bclk), 32'd1);

        wait_load(ur);
        checkOutput("frame1 underrun", 32'(ur), 32'd1);
        applyStimulus(16'hA5F0, 16'h0F0F);
        capture_word(w);
        checkOutput("frame1 silent word", w, 32'h0000_0000);

        wait_load(ur);
        checkOutput("frame2 underrun", 32'(ur), 32'd0);
        fork
            begin
                applyStimulus(16'h7FFF, 16'h8000);
                @(posedge clk);
                #1;
                checkOutput("ready low while P1 held", 32'(sample_ready), 32'd0);
                applyStimulus(16'h0001, 16'hFFFF);
            end
            begin
                capture_word(w);
                checkOutput("frame2 word", w, 32'hA5F0_0F0F);
                wait_load(ur);
                checkOutput("frame3 underrun", 32'(ur), 32'd0);
                capture_word(w);
                checkOutput("frame3 word P1", w, 32'h7FFF_8000);
                wait_load(ur);
                checkOutput("frame4 underrun", 32'(ur), 32'd0);
                capture_word(w);
                checkOutput("frame4 word P2", w, 32'h0001_FFFF);
            end
        join

        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (is_load(mt + 1)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout_fail("find load edge");
        sample_l = 16'h1234;
        sample_r = 16'h8001;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("collision frame_start", 32'(frame_start), 32'd1);
        checkOutput("collision underrun", 32'(underrun), 32'd1);
        checkOutput("collision pair held", 32'(sample_ready), 32'd0);
        @(negedge clk);
        sample_valid = 1'b0;
        capture_word(w);
        checkOutput("collision frame silent", w, 32'h0000_0000);
        wait_load(ur);
        checkOutput("after collision underrun", 32'(ur), 32'd0);
        fork
            applyStimulus(16'hDEAD, 16'hBEEF);
            begin
                capture_word(w);
                checkOutput("after collision word", w, 32'h1234_8001);
            end
        join

        wait_load(ur);
        checkOutput("frame7 underrun", 32'(ur), 32'd0);
        applyStimulus(16'h1111, 16'h2222);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (slot_of(mt) == 20) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout_fail("find slot 20");
        checkOutput("slot20 sdata before reset", 32'(o_sdata), 32'd1);
        checkOutput("slot20 lrclk before reset", 32'(o_lrclk), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("async reset sdata", 32'(o_sdata), 32'd0);
        checkOutput("async reset lrclk", 32'(o_lrclk), 32'd0);
        checkOutput("async reset bclk", 32'(o_bclk), 32'd0);
        checkOutput("async reset ready", 32'(sample_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_load(ur);
        checkOutput("post-reset underrun", 32'(ur), 32'd1);
        capture_word(w);
        checkOutput("post-reset word", w, 32'h0000_0000);

        for (int c = 0; c < 2560; c++) begin
            @(negedge clk);
            sample_valid = ($urandom_range(0, 3) == 0);
            sample_l = 16'($urandom);
            sample_r = 16'($urandom);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
